jedro_1_decode_stage: RTL and testbench
=======================================

JEDRO_1_DECODE_STAGE -- requirements
Module: jedro_1_decode_stage

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default 5: register-file address width on all rs/rd outputs.
REQ-002 Parameter IMM_WIDTH, default 32: width of imm_o; immediates are sign-extended to this width.
REQ-003 Parameter RV32E, default 0: when 1, any used register field with bit 4 set is illegal.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 instr_i  input  32  instruction word from fetch.
REQ-007 instr_valid_i  input  1  instr_i holds a valid instruction.
REQ-008 instr_ready_o  output  1  stage can accept an instruction this cycle.
REQ-009 flush_i  input  1  discard all held instructions.
REQ-010 dec_valid_o  output  1  decoded outputs are valid.
REQ-011 dec_ready_i  input  1  downstream consumes decoded outputs this cycle.
REQ-012 alu_op_sel_o  output  4  {funct7 bit, funct3} ALU operation.
REQ-013 rs1_addr_o / rs2_addr_o / rd_addr_o  output  RF_ADDR_WIDTH each  source/destination registers.
REQ-014 rd_we_o  output  1  instruction writes rd.
REQ-015 use_imm_o  output  1  ALU operand B is imm_o, not rs2.
REQ-016 imm_o  output  IMM_WIDTH  sign-extended immediate.
REQ-017 illegal_instr_o  output  1  instruction is illegal or unsupported.

Function
REQ-018 Transfer in: instr_valid_i && instr_ready_o; transfer out: dec_valid_o && dec_ready_i.
REQ-019 Storage: one output register plus one skid register; instr_ready_o is a registered signal = skid empty.
REQ-020 Accepted instruction is decoded combinationally and written to the output register when it is empty or drained the same cycle, otherwise to the skid register.
REQ-021 Skid entry moves to the output register on the cycle the output drains; order is strictly preserved.
REQ-022 Latency: accepted instruction appears on outputs the cycle after acceptance when the stage was empty.
REQ-023 Throughput: one instruction per cycle sustained while dec_ready_i = 1.
REQ-024 Outputs are stable while dec_valid_o = 1 and dec_ready_i = 0.
REQ-025 OPCODE_OP: alu_op_sel_o = {instr[30], funct3}, rs1/rs2/rd from instruction fields, rd_we_o = 1, use_imm_o = 0.
REQ-026 OPCODE_OPIMM: alu_op_sel_o = {funct3==101 ? instr[30] : 0, funct3}, imm_o = sign-extended instr[31:20], use_imm_o = 1, rd_we_o = 1, rs2_addr_o = 0.
REQ-027 OPCODE_LUI: alu_op_sel_o = 0000 (ADD), rs1_addr_o = 0, imm_o = {instr[31:12], 12'b0} sign-extended, use_imm_o = 1, rd_we_o = 1.
REQ-028 Illegal: instr[1:0] != 11; any other opcode; OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM funct3 001 with funct7 != 0000000 or 101 with funct7 not 0000000/0100000; RV32E violation.
REQ-029 Illegal instructions pass through the handshake normally with illegal_instr_o = 1, rd_we_o = 0, use_imm_o = 0, alu_op_sel_o = 0, all addresses 0, imm_o = 0.
REQ-030 flush_i = 1: output and skid registers invalidated next cycle; instr_valid_i that cycle is dropped; instr_ready_o = 1 next cycle.
REQ-031 flush_i overrides simultaneous accept, drain and rst_i-free transfers; rst_i overrides flush_i.

Reset
REQ-032 rst_i = 1 at a clock edge: dec_valid_o = 0, instr_ready_o = 1, both registers empty, all data outputs 0, illegal_instr_o = 0.
REQ-033 rst_i asserted mid-transfer discards held instructions; nothing is emitted after reset until a new acceptance.

Verification
REQ-034 Reset, then instr 0x00208133 (add x2,x1,x2) valid 1 cycle, dec_ready_i=1 -> next cycle dec_valid_o=1, alu_op_sel_o=0000, rs1=1, rs2=2, rd=2, rd_we_o=1.
REQ-035 Instr 0xFFF00093 (addi x1,x0,-1) -> use_imm_o=1, imm_o=0xFFFFFFFF, alu_op_sel_o=0000, rd=1.
REQ-036 dec_ready_i=0, three back-to-back valid instructions -> first two held, instr_ready_o=0 after second, third not accepted; release -> emitted in order, one per cycle.
REQ-037 Instr 0x0000006F (JAL) and 0x00000013 with bits[1:0]=00 -> illegal_instr_o=1, rd_we_o=0, handshake completes.
REQ-038 RV32E=1, add x16,x1,x2 -> illegal_instr_o=1; flush_i with both registers full -> dec_valid_o=0 next cycle, instr_ready_o=1.

Source files
------------

// File: rtl/jedro_1_decode_stage.sv
// RV32 decode stage for OP, OP-IMM and LUI instructions, with a two-entry
// (output + skid) buffer on the valid/ready handshake.
module jedro_1_decode_stage #(
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned IMM_WIDTH     = 32,
    parameter bit          RV32E         = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              instr_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic                     flush_i,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [3:0]               alu_op_sel_o,
    output logic [RF_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [RF_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic [RF_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                     rd_we_o,
    output logic                     use_imm_o,
    output logic [IMM_WIDTH-1:0]     imm_o,
    output logic                     illegal_instr_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic                     illegal;
        logic [3:0]               alu_op;
        logic [RF_ADDR_WIDTH-1:0] rs1;
        logic [RF_ADDR_WIDTH-1:0] rs2;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic                     rd_we;
        logic                     use_imm;
        logic [IMM_WIDTH-1:0]     imm;
    } dec_t;

    dec_t       dec_c;
    logic       legal;
    logic [2:0] funct3;
    logic [6:0] funct7;

    dec_t out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic rdy_q, rdy_d;
    logic accept, drain;

    // Combinational decode of the incoming word; illegal words collapse to all-zero fields.
    always_comb begin
        dec_c  = '0;
        legal  = 1'b0;
        funct3 = instr_i[14:12];
        funct7 = instr_i[31:25];
        case (instr_i[6:0])
            OPC_OP: begin
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                if (RV32E && (instr_i[19] || instr_i[24] || instr_i[11])) legal = 1'b0;
                dec_c.alu_op = {instr_i[30], funct3};
                dec_c.rs1    = RF_ADDR_WIDTH'(instr_i[19:15]);
                dec_c.rs2    = RF_ADDR_WIDTH'(instr_i[24:20]);
                dec_c.rd     = RF_ADDR_WIDTH'(instr_i[11:7]);
                dec_c.rd_we  = 1'b1;
            end
            OPC_OPIMM: begin
                legal = 1'b1;
                if ((funct3 == 3'b001) && (funct7 != F7_ZERO)) legal = 1'b0;
                if ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT)) legal = 1'b0;
                if (RV32E && (instr_i[19] || instr_i[11])) legal = 1'b0;
                dec_c.alu_op  = {(funct3 == 3'b101) ? instr_i[30] : 1'b0, funct3};
                dec_c.rs1     = RF_ADDR_WIDTH'(instr_i[19:15]);
                dec_c.rd      = RF_ADDR_WIDTH'(instr_i[11:7]);
                dec_c.rd_we   = 1'b1;
                dec_c.use_imm = 1'b1;
                dec_c.imm     = IMM_WIDTH'($signed(instr_i[31:20]));
            end
            OPC_LUI: begin
                legal = !(RV32E && instr_i[11]);
                dec_c.rd      = RF_ADDR_WIDTH'(instr_i[11:7]);
                dec_c.rd_we   = 1'b1;
                dec_c.use_imm = 1'b1;
                dec_c.imm     = IMM_WIDTH'($signed({instr_i[31:12], 12'b0}));
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_c         = '0;
            dec_c.illegal = 1'b1;
        end
    end

    // Buffer control: the skid entry always drains ahead of a new word to keep order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        accept       = instr_valid_i && rdy_q;
        drain        = out_valid_q && dec_ready_i;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        rdy_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
        end
    end

    assign instr_ready_o   = rdy_q;
    assign dec_valid_o     = out_valid_q;
    assign alu_op_sel_o    = out_q.alu_op;
    assign rs1_addr_o      = out_q.rs1;
    assign rs2_addr_o      = out_q.rs2;
    assign rd_addr_o       = out_q.rd;
    assign rd_we_o         = out_q.rd_we;
    assign use_imm_o       = out_q.use_imm;
    assign imm_o           = out_q.imm;
    assign illegal_instr_o = out_q.illegal;

endmodule

// File: tb/tb_jedro_1_decode_stage.sv
// Bench for jedro_1_decode_stage: directed scenarios plus randomized traffic
// against a queue-based reference model (RV32I and RV32E instances).
module tb_jedro_1_decode_stage;

    typedef struct packed {
        logic        ill;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ui;
        logic [31:0] imm;
    } exp_t;

    logic        clk;
    logic        rst, flush, instr_valid, dec_ready;
    logic [31:0] instr;

    logic rdy1, dv1, we1, ui1, ill1;
    logic [3:0] alu1;
    logic [4:0] rs1a1, rs2a1, rda1;
    logic [31:0] imm1;
    logic rdy2, dv2, we2, ui2, ill2;
    logic [3:0] alu2;
    logic [4:0] rs1a2, rs2a2, rda2;
    logic [31:0] imm2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q1[$];
    exp_t q2[$];

    jedro_1_decode_stage dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
        .instr_ready_o(rdy1), .flush_i(flush), .dec_valid_o(dv1), .dec_ready_i(dec_ready),
        .alu_op_sel_o(alu1), .rs1_addr_o(rs1a1), .rs2_addr_o(rs2a1), .rd_addr_o(rda1),
        .rd_we_o(we1), .use_imm_o(ui1), .imm_o(imm1), .illegal_instr_o(ill1)
    );

    jedro_1_decode_stage #(.RV32E(1'b1)) dut_e (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
        .instr_ready_o(rdy2), .flush_i(flush), .dec_valid_o(dv2), .dec_ready_i(dec_ready),
        .alu_op_sel_o(alu2), .rs1_addr_o(rs1a2), .rs2_addr_o(rs2a2), .rd_addr_o(rda2),
        .rd_we_o(we2), .use_imm_o(ui2), .imm_o(imm2), .illegal_instr_o(ill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t ref_dec(input logic [31:0] w, input bit e);
        exp_t r;
        bit ok;
        logic [6:0] f7;
        logic [2:0] f3;
        r  = '0;
        ok = 1'b0;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (e && (w[19] || w[24] || w[11])) ok = 1'b0;
            r.alu = {w[30], f3}; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
            r.we  = 1'b1;
        end else if (w[6:0] == 7'h13) begin
            ok = !(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            if (e && (w[19] || w[11])) ok = 1'b0;
            r.alu = (f3 == 3'd5) ? {w[30], f3} : {1'b0, f3};
            r.rs1 = w[19:15]; r.rd = w[11:7]; r.we = 1'b1; r.ui = 1'b1;
            r.imm = {{20{w[31]}}, w[31:20]};
        end else if (w[6:0] == 7'h37) begin
            ok = !(e && w[11]);
            r.rd = w[11:7]; r.we = 1'b1; r.ui = 1'b1;
            r.imm = {w[31:12], 12'h000};
        end
        if (!ok) begin
            r     = '0;
            r.ill = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 2);
        f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
        case ($urandom_range(0, 4))
            0: begin w[6:0] = 7'h33; w[31:25] = f7; end
            1: begin w[6:0] = 7'h13; end
            2: begin w[6:0] = 7'h37; end
            3: begin w[6:0] = 7'h13; w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5; w[31:25] = f7; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic exp_t obs1();
        return '{ill1, alu1, rs1a1, rs2a1, rda1, we1, ui1, imm1};
    endfunction

    function automatic exp_t obs2();
        return '{ill2, alu2, rs1a2, rs2a2, rda2, we2, ui2, imm2};
    endfunction

    // Applies one cycle of inputs at a falling edge and advances the model.
    task automatic drive_cycle(input logic v, input logic [31:0] w, input logic dr,
                               input logic fl, input logic rs);
        bit acc, drn;
        instr_valid = v; instr = w; dec_ready = dr; flush = fl; rst = rs;
        if (rs || fl) begin
            q1.delete();
            q2.delete();
        end else begin
            acc = v && (q1.size() < 2);
            drn = (q1.size() > 0) && dr;
            if (drn) begin
                void'(q1.pop_front());
                void'(q2.pop_front());
            end
            if (acc) begin
                q1.push_back(ref_dec(w, 1'b0));
                q2.push_back(ref_dec(w, 1'b1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dv1); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy1); end
        n_checks++;
        if (obs1() !== exp_t'(0)) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", obs1());
        end
    endtask

    task automatic test_add();
        drive_cycle(1'b1, 32'h00208133, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", dv1); end
        n_checks++;
        if ({alu1, rs1a1, rs2a1, rda1, we1, ui1, ill1} !== {4'd0, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_fields: got alu=%h rs1=%0d rs2=%0d rd=%0d we=%b ui=%b ill=%b want 0/1/2/2/1/0/0",
                     alu1, rs1a1, rs2a1, rda1, we1, ui1, ill1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", dv1); end
    endtask

    task automatic test_addi();
        drive_cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, ui1, imm1, alu1, rda1, rs2a1, we1} !== {1'b1, 1'b1, 32'hFFFFFFFF, 4'd0, 5'd1, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL addi_fields: got v=%b ui=%b imm=%h alu=%h rd=%0d rs2=%0d we=%b want 1/1/ffffffff/0/1/0/1",
                     dv1, ui1, imm1, alu1, rda1, rs2a1, we1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, rdy1, rda1} !== {1'b1, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL b2b_first: got v=%b rdy=%b rd=%0d want 1/1/1", dv1, rdy1, rda1);
        end
        drive_cycle(1'b1, 32'h00100113, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, rdy1, rda1} !== {1'b1, 1'b0, 5'd1}) begin
            n_fail++; $display("FAIL b2b_full: got v=%b rdy=%b rd=%0d want 1/0/1", dv1, rdy1, rda1);
        end
        drive_cycle(1'b1, 32'h00100193, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, rdy1, rda1} !== {1'b1, 1'b0, 5'd1}) begin
            n_fail++; $display("FAIL b2b_stall: got v=%b rdy=%b rd=%0d want 1/0/1", dv1, rdy1, rda1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, rdy1, rda1} !== {1'b1, 1'b1, 5'd2}) begin
            n_fail++; $display("FAIL b2b_second: got v=%b rdy=%b rd=%0d want 1/1/2", dv1, rdy1, rda1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL b2b_third_dropped: got %b want 0", dv1); end
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        words[0] = 32'h0000006F;
        words[1] = 32'h00000010;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, words[i], 1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({dv1, ill1, we1, ui1, alu1, rda1, rs1a1, rs2a1, imm1} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd0, 32'd0}) begin
                n_fail++;
                $display("FAIL illegal_%0d: got v=%b ill=%b we=%b ui=%b alu=%h rd=%0d imm=%h want 1/1/0/0/0/0/0",
                         i, dv1, ill1, we1, ui1, alu1, rda1, imm1);
            end
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL illegal_drain: got %b want 0", dv1); end
    endtask

    task automatic test_rv32e();
        drive_cycle(1'b1, 32'h00208833, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({ill2, we2, ill1, we1} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rv32e_x16: got e.ill=%b e.we=%b i.ill=%b i.we=%b want 1/0/0/1", ill2, we2, ill1, we1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00100113, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dv1, rdy1} !== 2'b10) begin n_fail++; $display("FAIL flush_pre: got v=%b rdy=%b want 1/0", dv1, rdy1); end
        drive_cycle(1'b1, 32'h00100193, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({dv1, rdy1} !== 2'b01) begin n_fail++; $display("FAIL flush_post: got v=%b rdy=%b want 0/1", dv1, rdy1); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", dv1); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00100113, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00100193, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({dv1, rdy1, imm1, rda1} !== {1'b0, 1'b1, 32'd0, 5'd0}) begin
            n_fail++; $display("FAIL reset_mid: got v=%b rdy=%b imm=%h rd=%0d want 0/1/0/0", dv1, rdy1, imm1, rda1);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_quiet: got %b want 0", dv1); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                        $urandom_range(0, 39) == 0, 1'b0);
            n_checks++;
            if (dv1 !== (q1.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, dv1, q1.size() > 0);
            end
            n_checks++;
            if (rdy1 !== (q1.size() < 2)) begin
                n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, rdy1, q1.size() < 2);
            end
            if (q1.size() > 0) begin
                n_checks++;
                if (obs1() !== q1[0]) begin
                    n_fail++; $display("FAIL rand_data c%0d: got %h want %h", c, obs1(), q1[0]);
                end
                n_checks++;
                if (obs2() !== q2[0]) begin
                    n_fail++; $display("FAIL rand_data_e c%0d: got %h want %h", c, obs2(), q2[0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0; instr = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_rv32e();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
